// File: rtl/relay_guard_pkg.sv
// relay_guard shared definitions.
// State encodings, fault cause codes and small helpers.
package relay_guard_pkg;

    localparam logic [2:0] ST_OFF      = 3'b000;
    localparam logic [2:0] ST_TURN_ON  = 3'b001;
    localparam logic [2:0] ST_ON       = 3'b010;
    localparam logic [2:0] ST_TURN_OFF = 3'b011;
    localparam logic [2:0] ST_STUCK    = 3'b100;

    localparam logic [1:0] FC_NONE       = 2'b00;
    localparam logic [1:0] FC_FAIL_CLOSE = 2'b01;
    localparam logic [1:0] FC_FAIL_OPEN  = 2'b10;
    localparam logic [1:0] FC_DROPOUT    = 2'b11;

    function automatic logic coil_on(input logic [2:0] st);
        return (st == ST_TURN_ON) || (st == ST_ON);
    endfunction

endpackage

// File: rtl/relay_fb_sync.sv
// relay_fb_sync: two-flop synchroniser for the contact feedback.
// Clears asynchronously with the block reset.
module relay_fb_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;

    // Two-stage metastability filter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/relay_guard.sv
// relay_guard: dwell-enforced relay coil drive with
// auxiliary-contact supervision and latched stuck fault.
module relay_guard
    import relay_guard_pkg::*;
#(
    parameter int unsigned MIN_ON_CYC     = 50000,
    parameter int unsigned MIN_OFF_CYC    = 50000,
    parameter int unsigned FB_TIMEOUT_CYC = 20000,
    parameter int unsigned CNT_W          = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       relay_req,
    input  logic       relay_fb,
    input  logic       clear_fault,
    output logic       relay_coil,
    output logic       stuck_fault,
    output logic [1:0] fault_code,
    output logic [2:0] state_dbg
);

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(MIN_ON_CYC - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(MIN_OFF_CYC - 1);
    localparam logic [CNT_W-1:0] FB_LAST  = CNT_W'(FB_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             fb_s;
    logic [2:0]       state;
    logic [2:0]       state_n;
    logic [1:0]       code_n;
    logic [CNT_W-1:0] cnt;

    relay_fb_sync u_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (relay_fb),
        .q     (fb_s)
    );

    // Next state and fault cause; feedback wins over timeout
    always_comb begin
        state_n = state;
        code_n  = fault_code;
        case (state)
            ST_OFF: begin
                if (relay_req && cnt >= OFF_LAST)
                    state_n = ST_TURN_ON;
            end
            ST_TURN_ON: begin
                if (fb_s) begin
                    state_n = ST_ON;
                end else if (cnt >= FB_LAST) begin
                    state_n = ST_STUCK;
                    code_n  = FC_FAIL_CLOSE;
                end
            end
            ST_ON: begin
                if (!fb_s) begin
                    state_n = ST_STUCK;
                    code_n  = FC_DROPOUT;
                end else if (!relay_req && cnt >= ON_LAST) begin
                    state_n = ST_TURN_OFF;
                end
            end
            ST_TURN_OFF: begin
                if (!fb_s) begin
                    state_n = ST_OFF;
                end else if (cnt >= FB_LAST) begin
                    state_n = ST_STUCK;
                    code_n  = FC_FAIL_OPEN;
                end
            end
            ST_STUCK: begin
                if (clear_fault && !relay_req) begin
                    state_n = ST_OFF;
                    code_n  = FC_NONE;
                end
            end
            default: begin
                state_n = ST_STUCK;
                code_n  = FC_NONE;
            end
        endcase
    end

    // State, shared dwell/timeout counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_OFF;
            cnt         <= '0;
            relay_coil  <= 1'b0;
            stuck_fault <= 1'b0;
            fault_code  <= FC_NONE;
        end else begin
            state       <= state_n;
            relay_coil  <= coil_on(state_n);
            stuck_fault <= (state_n == ST_STUCK);
            fault_code  <= code_n;
            if (state_n != state)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + CNT_W'(1);
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_relay_guard.sv
// tb_relay_guard: scoreboard bench for relay_guard.
// Expected state transitions are queued; a monitor checks them.
module tb_relay_guard;
    import relay_guard_pkg::*;

    typedef struct {
        logic [2:0] st;
        logic       coil;
        logic       stk;
        logic [1:0] code;
        int         dwell;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       relay_req = 1'b0;
    logic       relay_fb;
    logic       clear_fault = 1'b0;
    logic       relay_coil;
    logic       stuck_fault;
    logic [1:0] fault_code;
    logic [2:0] state_dbg;

    int   errors = 0;
    int   checks = 0;
    int   mode = 0;
    int   ntrans = 0;
    logic fbd1 = 1'b0;
    logic fbd2 = 1'b0;
    exp_t q[$];

    relay_guard #(
        .MIN_ON_CYC     (8),
        .MIN_OFF_CYC    (8),
        .FB_TIMEOUT_CYC (6),
        .CNT_W          (17)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .relay_req   (relay_req),
        .relay_fb    (relay_fb),
        .clear_fault (clear_fault),
        .relay_coil  (relay_coil),
        .stuck_fault (stuck_fault),
        .fault_code  (fault_code),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    // Contact model: follows the coil 2 cycles late, or tied
    always @(posedge clk) begin
        fbd1 <= relay_coil;
        fbd2 <= fbd1;
    end
    assign relay_fb = (mode == 1) ? 1'b0 :
                      (mode == 2) ? 1'b1 : fbd2;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_tr(input logic [2:0] st, input logic coil,
                             input logic stk, input logic [1:0] code,
                             input int dwell);
        exp_t e;
        e.st = st; e.coil = coil; e.stk = stk;
        e.code = code; e.dwell = dwell;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [7:0] got,
                       input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n = 0;
        while (state_dbg !== s && n < budget) begin
            tick(1);
            n++;
        end
        if (state_dbg !== s) begin
            checks++;
            errors++;
            $display("FAIL wait_state: got st=%0d want st=%0d",
                     state_dbg, s);
        end
    endtask

    // Monitor: on every state change pop and compare one transition
    initial begin
        logic [2:0] last;
        int dwell;
        exp_t e;
        last = ST_OFF;
        dwell = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                last = state_dbg;
                dwell = 0;
            end else if (state_dbg !== last) begin
                ntrans++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL trans%0d: got st=%0d with nothing expected",
                             ntrans, state_dbg);
                end else begin
                    e = q.pop_front();
                    if (state_dbg !== e.st || relay_coil !== e.coil ||
                        stuck_fault !== e.stk || fault_code !== e.code ||
                        dwell != e.dwell) begin
                        errors++;
                        $display({"FAIL trans%0d: got st=%0d coil=%b stk=%b ",
                                  "code=%0d dwell=%0d want st=%0d coil=%b ",
                                  "stk=%b code=%0d dwell=%0d"},
                                 ntrans, state_dbg, relay_coil, stuck_fault,
                                 fault_code, dwell, e.st, e.coil, e.stk,
                                 e.code, e.dwell);
                    end
                end
                last = state_dbg;
                dwell = 1;
            end else begin
                dwell++;
            end
        end
    end

    initial begin
        int n;
        tick(2);
        chk("reset_state", {1'b0, state_dbg, relay_coil, stuck_fault,
                            fault_code}, 8'h00);

        // Power-up closure with request held from reset
        expect_tr(ST_TURN_ON, 1, 0, FC_NONE, 8);
        expect_tr(ST_ON,      1, 0, FC_NONE, 5);
        relay_req = 1'b1;
        reset = 1'b1;
        wait_state(ST_ON, 40);

        // Early release waits out the minimum on time
        expect_tr(ST_TURN_OFF, 0, 0, FC_NONE, 8);
        expect_tr(ST_OFF,      0, 0, FC_NONE, 5);
        tick(2);
        relay_req = 1'b0;
        wait_state(ST_OFF, 40);

        // Contact never closes
        expect_tr(ST_TURN_ON, 1, 0, FC_NONE,       8);
        expect_tr(ST_STUCK,   0, 1, FC_FAIL_CLOSE, 6);
        expect_tr(ST_OFF,     0, 0, FC_NONE,       1);
        mode = 1;
        relay_req = 1'b1;
        wait_state(ST_STUCK, 40);
        relay_req = 1'b0;
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        wait_state(ST_OFF, 10);

        // Contact welded closed
        expect_tr(ST_TURN_ON,  1, 0, FC_NONE,      8);
        expect_tr(ST_ON,       1, 0, FC_NONE,      5);
        expect_tr(ST_TURN_OFF, 0, 0, FC_NONE,      8);
        expect_tr(ST_STUCK,    0, 1, FC_FAIL_OPEN, 6);
        expect_tr(ST_OFF,      0, 0, FC_NONE,      1);
        mode = 0;
        relay_req = 1'b1;
        wait_state(ST_ON, 40);
        relay_req = 1'b0;
        wait_state(ST_TURN_OFF, 40);
        mode = 2;
        wait_state(ST_STUCK, 40);
        mode = 0;
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        wait_state(ST_OFF, 10);

        // Dropout, ignored clear, accepted clear, full off wait
        expect_tr(ST_TURN_ON, 1, 0, FC_NONE,    8);
        expect_tr(ST_ON,      1, 0, FC_NONE,    5);
        expect_tr(ST_STUCK,   0, 1, FC_DROPOUT, 3);
        expect_tr(ST_OFF,     0, 0, FC_NONE,    6);
        expect_tr(ST_TURN_ON, 1, 0, FC_NONE,    8);
        relay_req = 1'b1;
        wait_state(ST_ON, 40);
        mode = 1;
        wait_state(ST_STUCK, 20);
        tick(2);
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        chk("clear_with_req", {6'b0, stuck_fault, relay_coil}, 8'h02);
        chk("code_held", {6'b0, fault_code}, 8'h03);
        tick(2);
        relay_req = 1'b0;
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        wait_state(ST_OFF, 5);
        mode = 0;
        relay_req = 1'b1;
        wait_state(ST_TURN_ON, 40);

        // Asynchronous reset in the middle of a closure
        expect_tr(ST_TURN_ON, 1, 0, FC_NONE, 8);
        expect_tr(ST_ON,      1, 0, FC_NONE, 5);
        tick(2);
        reset = 1'b0;
        #1;
        chk("async_coil", {7'b0, relay_coil}, 8'h00);
        chk("async_state", {5'b0, state_dbg}, 8'h00);
        tick(2);
        reset = 1'b1;
        wait_state(ST_ON, 40);

        n = 0;
        while (q.size() > 0 && n < 20) begin
            tick(1);
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        tick(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
